// File: rtl/psram_pkg.sv
// Shared types and defaults for the two-port PSRAM front end.
package psram_pkg;

   localparam int ADDR_W_DEF = 24;
   localparam int DATA_W_DEF = 16;
   localparam int TMO_W      = 10;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_ISSUE       = 3'd1,
      ST_WAIT_ACCEPT = 3'd2,
      ST_WAIT_DONE   = 3'd3,
      ST_RESPOND     = 3'd4
   } arb_state_e;

   typedef enum logic {
      PORT_VID = 1'b0,
      PORT_CPU = 1'b1
   } arb_port_e;

endpackage

// File: rtl/psram_arb_priority.sv
// Video-first grant selection with a starvation counter that eventually forces
// a waiting CPU request through.
module psram_arb_priority
   import psram_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_vid_req,
   input  logic i_cpu_req,
   input  logic i_en,
   output logic o_grant_vid,
   output logic o_grant_cpu
);

   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_q;
   logic [CNT_W-1:0] starve_cnt_d;
   logic             starve_full;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v >= CNT_MAX) begin
         return CNT_MAX;
      end
      return v + 1'b1;
   endfunction

   assign starve_full = (starve_cnt_q == CNT_MAX);

   always_comb begin
      o_grant_cpu = i_en && i_cpu_req && (!i_vid_req || starve_full);
      o_grant_vid = i_en && i_vid_req && !(i_cpu_req && starve_full);
   end

   // The count only measures how long the CPU has been kept waiting, so it
   // restarts whenever the CPU is not asking or has just been served.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!i_cpu_req || o_grant_cpu) begin
         starve_cnt_d = '0;
      end else if (o_grant_vid) begin
         starve_cnt_d = sat_inc(starve_cnt_q);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/psram_port_arbiter.sv
// Video/CPU front end for the PSRAM controller: grants one port, runs the
// stb/busy/done handshake, and completes each request with a one-cycle ack.
module psram_port_arbiter
   import psram_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 1023
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_vid_req,
   input  logic [ADDR_W-1:0] i_vid_addr,
   output logic              o_vid_ack,
   output logic [DATA_W-1:0] o_vid_rdata,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_ack,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic              o_err,
   output logic              o_stb,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_din,
   input  logic              i_busy,
   input  logic              i_done,
   input  logic [DATA_W-1:0] i_dout
);

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   arb_state_e        state_q, state_d;
   arb_port_e         port_q, port_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              err_q, err_d;
   logic              vid_ack_q, vid_ack_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

   logic arb_en;
   logic grant_vid;
   logic grant_cpu;
   logic finished;
   logic tmo_hit;
   logic tmo_exit;
   logic rd_cap;

   assign arb_en   = (state_q == ST_IDLE) && !i_busy;
   assign finished = !i_busy && i_done;
   assign tmo_hit  = (tmo_q == TMO_LAST);

   psram_arb_priority #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_priority (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_vid_req   (i_vid_req),
      .i_cpu_req   (i_cpu_req),
      .i_en        (arb_en),
      .o_grant_vid (grant_vid),
      .o_grant_cpu (grant_cpu)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A real accept or completion takes precedence over a timeout in the same cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:        if (grant_vid || grant_cpu) state_d = ST_ISSUE;
         ST_ISSUE:       state_d = ST_WAIT_ACCEPT;
         ST_WAIT_ACCEPT: if (i_busy) state_d = ST_WAIT_DONE;
                         else if (tmo_hit) state_d = ST_RESPOND;
         ST_WAIT_DONE:   if (finished || tmo_hit) state_d = ST_RESPOND;
         ST_RESPOND:     state_d = ST_IDLE;
         default:        state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_stb    = (state_q == ST_ISSUE) || (state_q == ST_WAIT_ACCEPT);
      tmo_exit = ((state_q == ST_WAIT_ACCEPT) && !i_busy && tmo_hit) ||
                 ((state_q == ST_WAIT_DONE) && !finished && tmo_hit);
      rd_cap   = (state_q == ST_WAIT_DONE) && finished && !we_q;

      port_d = port_q;
      we_d   = we_q;
      addr_d = addr_q;
      din_d  = din_q;
      if (grant_cpu) begin
         port_d = PORT_CPU;
         we_d   = i_cpu_we;
         addr_d = i_cpu_addr;
         din_d  = i_cpu_wdata;
      end else if (grant_vid) begin
         port_d = PORT_VID;
         we_d   = 1'b0;
         addr_d = i_vid_addr;
         din_d  = '0;
      end

      // Counter restarts on every state change so each wait gets a full budget.
      tmo_d = tmo_q;
      if (state_d != state_q) begin
         tmo_d = '0;
      end else if ((state_q == ST_WAIT_ACCEPT) || (state_q == ST_WAIT_DONE)) begin
         tmo_d = tmo_q + 1'b1;
      end

      err_d     = tmo_exit;
      vid_ack_d = (state_d == ST_RESPOND) && (port_q == PORT_VID);
      cpu_ack_d = (state_d == ST_RESPOND) && (port_q == PORT_CPU);

      vid_rdata_d = (rd_cap && (port_q == PORT_VID)) ? i_dout : vid_rdata_q;
      cpu_rdata_d = (rd_cap && (port_q == PORT_CPU)) ? i_dout : cpu_rdata_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         port_q      <= PORT_VID;
         we_q        <= 1'b0;
         addr_q      <= '0;
         din_q       <= '0;
         tmo_q       <= '0;
         err_q       <= 1'b0;
         vid_ack_q   <= 1'b0;
         cpu_ack_q   <= 1'b0;
         vid_rdata_q <= '0;
         cpu_rdata_q <= '0;
      end else begin
         port_q      <= port_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         tmo_q       <= tmo_d;
         err_q       <= err_d;
         vid_ack_q   <= vid_ack_d;
         cpu_ack_q   <= cpu_ack_d;
         vid_rdata_q <= vid_rdata_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

   assign o_we        = we_q;
   assign o_addr      = addr_q;
   assign o_din       = din_q;
   assign o_err       = err_q;
   assign o_vid_ack   = vid_ack_q;
   assign o_cpu_ack   = cpu_ack_q;
   assign o_vid_rdata = vid_rdata_q;
   assign o_cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Directed bench for psram_port_arbiter with a small behavioural controller model.
module tb_psram_port_arbiter;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_ack;
   logic [DATA_W-1:0] vid_rdata;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic              err;
   logic              stb;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic              busy = 1'b1;
   logic              done = 1'b0;
   logic [DATA_W-1:0] dout = '0;

   int checks   = 0;
   int failures = 0;

   int              mdl_cnt   = 0;
   int              mdl_lat   = 3;
   bit              mdl_init  = 1'b1;
   bit              mdl_hang  = 1'b0;
   logic [DATA_W-1:0] mdl_rdata = '0;

   always #5 clk = ~clk;

   psram_port_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .STARVE_LIMIT (4),
      .TIMEOUT      (1023)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_vid_req   (vid_req),
      .i_vid_addr  (vid_addr),
      .o_vid_ack   (vid_ack),
      .o_vid_rdata (vid_rdata),
      .i_cpu_req   (cpu_req),
      .i_cpu_we    (cpu_we),
      .i_cpu_addr  (cpu_addr),
      .i_cpu_wdata (cpu_wdata),
      .o_cpu_ack   (cpu_ack),
      .o_cpu_rdata (cpu_rdata),
      .o_err       (err),
      .o_stb       (stb),
      .o_we        (we),
      .o_addr      (addr),
      .o_din       (din),
      .i_busy      (busy),
      .i_done      (done),
      .i_dout      (dout)
   );

   // Controller model: accepts stb by raising busy, finishes mdl_lat cycles later.
   always @(negedge clk) begin
      if (mdl_init) begin
         busy = 1'b1; done = 1'b0; mdl_cnt = 0;
      end else if (!rst_n) begin
         busy = 1'b0; done = 1'b0; mdl_cnt = 0;
      end else if (mdl_cnt > 0) begin
         mdl_cnt = mdl_cnt - 1;
         if (mdl_cnt == 0) begin
            busy = 1'b0; done = 1'b1; dout = mdl_rdata;
         end
      end else if (busy) begin
         busy = 1'b0;
      end else if (stb && !mdl_hang) begin
         busy = 1'b1; done = 1'b0; mdl_cnt = mdl_lat;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input int limit, output bit timed_out, output int stb_cycles);
      int n;
      n = 0;
      stb_cycles = 0;
      do begin
         tick();
         n++;
         if (stb) stb_cycles++;
      end while (!(vid_ack || cpu_ack) && n < limit);
      timed_out = !(vid_ack || cpu_ack);
   endtask

   task automatic wait_stb(input logic level, input int limit);
      int n;
      n = 0;
      while (stb !== level && n < limit) begin
         tick();
         n++;
      end
   endtask

   initial begin
      bit to;
      int sn;
      int cnt;

      rst_n = 1'b0; vid_req = 1'b0; vid_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (3) tick();
      check("rst_ctrl", {stb, we, vid_ack, cpu_ack, err}, 0);
      check("rst_addr", addr, 0);
      check("rst_din", din, 0);
      check("rst_rdata", {vid_rdata, cpu_rdata}, 0);

      // Controller still initialising: video request must wait.
      rst_n = 1'b1; vid_req = 1'b1; vid_addr = 24'h00ABCD;
      cnt = 0;
      repeat (50) begin
         tick();
         if (stb) cnt++;
      end
      check("t1_no_stb_while_busy", cnt, 0);
      mdl_init = 1'b0; mdl_rdata = 16'h1111;
      wait_stb(1'b1, 10);
      check("t1_stb", stb, 1);
      check("t1_addr", addr, 32'h00ABCD);
      check("t1_we", we, 0);
      wait_ack(50, to, sn);
      check("t1_timeout", to, 0);
      check("t1_acks", {vid_ack, cpu_ack, err}, 3'b100);
      check("t1_rdata", vid_rdata, 16'h1111);
      vid_req = 1'b0;
      tick();
      check("t1_single_ack", vid_ack, 0);

      // CPU read.
      mdl_rdata = 16'h5A5A;
      cpu_we = 1'b0; cpu_addr = 24'h000042; cpu_req = 1'b1;
      wait_ack(50, to, sn);
      check("t3_timeout", to, 0);
      check("t3_acks", {vid_ack, cpu_ack, err}, 3'b010);
      check("t3_rdata", cpu_rdata, 16'h5A5A);
      check("t3_addr", addr, 32'h000042);
      cpu_req = 1'b0;
      tick();
      check("t3_single_ack", cpu_ack, 0);

      // CPU write; inputs changed after grant must not leak through.
      mdl_rdata = 16'hDEAD;
      cpu_we = 1'b1; cpu_addr = 24'h001234; cpu_wdata = 16'hBEEF; cpu_req = 1'b1;
      wait_stb(1'b1, 10);
      check("t2_stb", stb, 1);
      check("t2_we", we, 1);
      check("t2_addr", addr, 32'h001234);
      check("t2_din", din, 16'hBEEF);
      cpu_addr = 24'h000000; cpu_wdata = 16'h0000; cpu_we = 1'b0;
      wait_ack(50, to, sn);
      check("t2_timeout", to, 0);
      check("t2_acks", {vid_ack, cpu_ack, err}, 3'b010);
      check("t2_rdata_kept", cpu_rdata, 16'h5A5A);
      check("t2_fields_held", {we, addr[15:0], din}, {1'b1, 16'h1234, 16'hBEEF});
      cpu_req = 1'b0;
      tick();
      check("t2_single_ack", cpu_ack, 0);

      // Both ports held continuously: V V V V C V V V V C.
      mdl_rdata = 16'h7777;
      vid_addr = 24'h000100; cpu_we = 1'b0; cpu_addr = 24'h000200;
      vid_req = 1'b1; cpu_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wait_ack(50, to, sn);
         check($sformatf("t4_timeout_%0d", i), to, 0);
         check($sformatf("t4_order_%0d", i), {vid_ack, cpu_ack},
               (i == 4 || i == 9) ? 2'b01 : 2'b10);
         if (i == 9) begin
            vid_req = 1'b0; cpu_req = 1'b0;
         end
         tick();
         check($sformatf("t4_no_double_%0d", i), {vid_ack, cpu_ack}, 2'b00);
      end

      // Controller never accepts: timeout completion.
      mdl_hang = 1'b1; mdl_rdata = 16'h9999;
      vid_addr = 24'h0000F0; vid_req = 1'b1;
      wait_ack(1100, to, sn);
      check("t5_timeout_bound", to, 0);
      check("t5_ack_err", {vid_ack, cpu_ack, err}, 3'b101);
      check("t5_stb_low", stb, 0);
      check("t5_stb_cycles", sn, 1024);
      check("t5_rdata_kept", vid_rdata, 16'h7777);
      vid_req = 1'b0;
      tick();
      check("t5_pulse_end", {vid_ack, err}, 2'b00);
      cnt = 0;
      repeat (3) begin
         tick();
         if (stb || vid_ack || cpu_ack) cnt++;
      end
      check("t5_idle_after", cnt, 0);
      mdl_hang = 1'b0;

      // Reset in WAIT_DONE, then the re-presented request completes.
      mdl_lat = 20; mdl_rdata = 16'h3C3C;
      vid_addr = 24'h0000AA; vid_req = 1'b1;
      wait_stb(1'b1, 10);
      check("t6_stb", stb, 1);
      wait_stb(1'b0, 10);
      check("t6_accepted", {stb, busy}, 2'b01);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      check("t6_rst_ctrl", {stb, we, vid_ack, cpu_ack, err}, 0);
      check("t6_rst_addr", addr, 0);
      check("t6_rst_data", {din, vid_rdata}, 0);
      check("t6_rst_cpu_rdata", cpu_rdata, 0);
      cnt = 0;
      repeat (3) begin
         tick();
         if (vid_ack || cpu_ack || stb) cnt++;
      end
      check("t6_quiet_in_reset", cnt, 0);
      mdl_lat = 3;
      rst_n = 1'b1;
      wait_ack(60, to, sn);
      check("t6_timeout", to, 0);
      check("t6_acks", {vid_ack, cpu_ack, err}, 3'b100);
      check("t6_rdata", vid_rdata, 16'h3C3C);
      check("t6_addr", addr, 32'h0000AA);
      vid_req = 1'b0;
      tick();
      check("t6_single_ack", vid_ack, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
